hmem_arb: RTL and testbench

- Arbiter and sequencer sharing the single higher-level memory bus (h_*) between the instruction-cache miss port (read-only) and the data-cache port (read/write).
- Sits between the L1 cache controllers and the next memory level.
- Grants one transaction at a time using round-robin.
- After every completed data write, emits an invalidation pulse toward the instruction cache so it does not hold stale lines.

---
 rtl/hmem_arb.sv | 177 +++++++++++++++++
 tb/tb_hmem_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hmem_arb.sv
// Round-robin arbiter sharing one memory bus between the I-cache miss port (read-only)
// and the D-cache port (read/write). After each completed D write, it pulses an
// invalidate to the I-cache so the I-cache does not keep stale lines.
module hmem_arb #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINE_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache miss port
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  output logic [LINE_W-1:0] i_data,
  output logic              i_dv,
  // D-cache port
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_dv,
  // Shared memory bus
  output logic [ADDR_W-1:0] h_addr,
  output logic              h_rd,
  output logic              h_wr,
  output logic [LINE_W-1:0] h_wdata,
  input  logic [LINE_W-1:0] h_rdata,
  input  logic              h_dv,
  // I-cache invalidate
  output logic [ADDR_W-1:0] inv_addr,
  output logic              inv
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StDone} state_e;

  localparam logic SideI = 1'b0;
  localparam logic SideD = 1'b1;

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] h_addr_q, h_addr_d;
  logic [LINE_W-1:0] h_wdata_q, h_wdata_d;
  logic              h_rd_q, h_rd_d;
  logic              h_wr_q, h_wr_d;
  logic [LINE_W-1:0] i_data_q, i_data_d;
  logic              i_dv_q, i_dv_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_dv_q, d_dv_d;
  logic [ADDR_W-1:0] inv_addr_q, inv_addr_d;
  logic              inv_q, inv_d;

  logic d_req;
  logic grant_i;
  logic grant_d;

  // Arbitration: on a tie, grant the side that did not win last time.
  always_comb begin
    d_req   = d_rd | d_wr;
    grant_i = i_rd & (~d_req | (rr_last_q == SideD));
    grant_d = d_req & ~grant_i;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    h_addr_d   = h_addr_q;
    h_wdata_d  = h_wdata_q;
    h_rd_d     = h_rd_q;
    h_wr_d     = h_wr_q;
    i_data_d   = i_data_q;
    i_dv_d     = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_dv_d     = 1'b0;
    inv_addr_d = inv_addr_q;
    inv_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d   = StGrantI;
          rr_last_d = SideI;
          h_addr_d  = i_addr;
          h_rd_d    = 1'b1;
        end else if (grant_d) begin
          state_d   = StGrantD;
          rr_last_d = SideD;
          h_addr_d  = d_addr;
          h_wdata_d = d_wdata;
          // A simultaneous read+write request is treated as a write.
          h_wr_d    = d_wr;
          h_rd_d    = ~d_wr;
        end
      end
      StGrantI: begin
        if (h_dv) begin
          state_d  = StDone;
          h_rd_d   = 1'b0;
          i_data_d = h_rdata;
          i_dv_d   = 1'b1;
        end
      end
      StGrantD: begin
        if (h_dv) begin
          state_d = StDone;
          h_rd_d  = 1'b0;
          h_wr_d  = 1'b0;
          d_dv_d  = 1'b1;
          // h_wr_q still holds the latched direction of this grant.
          if (h_wr_q) begin
            inv_d      = 1'b1;
            inv_addr_d = h_addr_q;
          end else begin
            d_rdata_d = h_rdata;
          end
        end
      end
      StDone: begin
        // One dead cycle lets the requester drop its level request after dv.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset also drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q  <= SideD;
      h_addr_q   <= '0;
      h_wdata_q  <= '0;
      h_rd_q     <= 1'b0;
      h_wr_q     <= 1'b0;
      i_data_q   <= '0;
      i_dv_q     <= 1'b0;
      d_rdata_q  <= '0;
      d_dv_q     <= 1'b0;
      inv_addr_q <= '0;
      inv_q      <= 1'b0;
    end else begin
      rr_last_q  <= rr_last_d;
      h_addr_q   <= h_addr_d;
      h_wdata_q  <= h_wdata_d;
      h_rd_q     <= h_rd_d;
      h_wr_q     <= h_wr_d;
      i_data_q   <= i_data_d;
      i_dv_q     <= i_dv_d;
      d_rdata_q  <= d_rdata_d;
      d_dv_q     <= d_dv_d;
      inv_addr_q <= inv_addr_d;
      inv_q      <= inv_d;
    end
  end

  assign h_addr   = h_addr_q;
  assign h_wdata  = h_wdata_q;
  assign h_rd     = h_rd_q;
  assign h_wr     = h_wr_q;
  assign i_data   = i_data_q;
  assign i_dv     = i_dv_q;
  assign d_rdata  = d_rdata_q;
  assign d_dv     = d_dv_q;
  assign inv_addr = inv_addr_q;
  assign inv      = inv_q;

endmodule

// File: tb/tb_hmem_arb.sv
// Directed bench for hmem_arb; inputs driven and outputs sampled on the falling edge.
module tb_hmem_arb;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned LINE_W = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_addr;
  logic              i_rd;
  logic [LINE_W-1:0] i_data;
  logic              i_dv;
  logic [ADDR_W-1:0] d_addr;
  logic              d_rd;
  logic              d_wr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_dv;
  logic [ADDR_W-1:0] h_addr;
  logic              h_rd;
  logic              h_wr;
  logic [LINE_W-1:0] h_wdata;
  logic [LINE_W-1:0] h_rdata;
  logic              h_dv;
  logic [ADDR_W-1:0] inv_addr;
  logic              inv;

  int n_checks = 0;
  int n_bad    = 0;
  int rd_bursts = 0;
  logic h_rd_prev = 1'b0;

  hmem_arb #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_addr  (i_addr),
    .i_rd    (i_rd),
    .i_data  (i_data),
    .i_dv    (i_dv),
    .d_addr  (d_addr),
    .d_rd    (d_rd),
    .d_wr    (d_wr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_dv    (d_dv),
    .h_addr  (h_addr),
    .h_rd    (h_rd),
    .h_wr    (h_wr),
    .h_wdata (h_wdata),
    .h_rdata (h_rdata),
    .h_dv    (h_dv),
    .inv_addr(inv_addr),
    .inv     (inv)
  );

  always #5 clk = ~clk;

  // Count rising edges of the memory read strobe.
  always @(negedge clk) begin
    if (h_rd && !h_rd_prev) rd_bursts = rd_bursts + 1;
    h_rd_prev = h_rd;
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  localparam logic [LINE_W-1:0] LineA5 = {64{8'hA5}};
  localparam logic [LINE_W-1:0] LineW1 = {16{32'h12345678}};
  localparam logic [LINE_W-1:0] LineW2 = {16{32'hCAFEF00D}};
  localparam logic [LINE_W-1:0] LineJunk = {16{32'hDEADBEEF}};

  logic [LINE_W-1:0] rdata_k;
  logic [ADDR_W-1:0] addr_k;
  int                burst_base;

  initial begin
    rst = 1'b1; i_addr = '0; i_rd = 1'b0; d_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_wdata = '0; h_rdata = '0; h_dv = 1'b0;
    tick; tick;

    // Reset state
    check("rst_h_rd", h_rd, 0);
    check("rst_h_wr", h_wr, 0);
    check("rst_h_addr", h_addr, 0);
    check("rst_i_dv", i_dv, 0);
    check("rst_d_dv", d_dv, 0);
    check("rst_inv", inv, 0);
    check("rst_i_data", i_data, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    tick;

    // Single I read, memory answers after 4 cycles
    i_rd = 1'b1; i_addr = 64'h1000;
    tick;
    check("i1_h_rd", h_rd, 1);
    check("i1_h_addr", h_addr, 64'h1000);
    check("i1_h_wr", h_wr, 0);
    tick; tick;
    check("i1_h_rd_hold", h_rd, 1);
    tick;
    h_dv = 1'b1; h_rdata = LineA5;
    tick;
    h_dv = 1'b0; h_rdata = '0;
    check("i1_i_dv", i_dv, 1);
    check("i1_i_data", i_data, LineA5);
    check("i1_h_rd_drop", h_rd, 0);
    i_rd = 1'b0;
    tick;
    check("i1_i_dv_pulse", i_dv, 0);
    check("i1_i_data_hold", i_data, LineA5);

    // D write with invalidate
    d_wr = 1'b1; d_addr = 64'h2040; d_wdata = LineW1;
    tick;
    check("dw_h_wr", h_wr, 1);
    check("dw_h_rd", h_rd, 0);
    check("dw_h_addr", h_addr, 64'h2040);
    check("dw_h_wdata", h_wdata, LineW1);
    tick;
    h_dv = 1'b1; h_rdata = LineJunk;
    tick;
    h_dv = 1'b0;
    check("dw_d_dv", d_dv, 1);
    check("dw_inv", inv, 1);
    check("dw_inv_addr", inv_addr, 64'h2040);
    check("dw_h_wr_drop", h_wr, 0);
    check("dw_i_dv", i_dv, 0);
    check("dw_d_rdata_kept", d_rdata, 0);
    d_wr = 1'b0;
    tick;
    check("dw_inv_pulse", inv, 0);
    check("dw_d_dv_pulse", d_dv, 0);

    // Read+write together is a write
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 64'h3000; d_wdata = LineW2;
    tick;
    check("rw_h_wr", h_wr, 1);
    check("rw_h_rd", h_rd, 0);
    tick;
    check("rw_h_rd_still", h_rd, 0);
    h_dv = 1'b1; h_rdata = LineJunk;
    tick;
    h_dv = 1'b0;
    check("rw_inv", inv, 1);
    check("rw_inv_addr", inv_addr, 64'h3000);
    check("rw_d_dv", d_dv, 1);
    check("rw_h_rd_never", h_rd, 0);
    d_rd = 1'b0; d_wr = 1'b0;
    tick;

    // Spurious h_dv in IDLE
    h_dv = 1'b1; h_rdata = LineJunk;
    tick;
    h_dv = 1'b0;
    check("sp_i_dv", i_dv, 0);
    check("sp_d_dv", d_dv, 0);
    check("sp_inv", inv, 0);
    check("sp_d_rdata", d_rdata, 0);
    tick;

    // Back-to-back I reads, memory latency 1
    burst_base = rd_bursts;
    i_rd = 1'b1; i_addr = 64'h1100;
    tick;
    check("bb_h_rd1", h_rd, 1);
    h_dv = 1'b1; h_rdata = LineW1;
    tick;
    h_dv = 1'b0;
    check("bb_i_dv1", i_dv, 1);
    check("bb_i_data1", i_data, LineW1);
    i_rd = 1'b0;
    tick;
    i_rd = 1'b1; i_addr = 64'h1140;
    check("bb_gap", h_rd, 0);
    tick;
    check("bb_h_rd2", h_rd, 1);
    check("bb_h_addr2", h_addr, 64'h1140);
    h_dv = 1'b1; h_rdata = LineW2;
    tick;
    h_dv = 1'b0;
    check("bb_i_dv2", i_dv, 1);
    check("bb_i_data2", i_data, LineW2);
    i_rd = 1'b0;
    tick; tick;
    check("bb_no_third", h_rd, 0);
    check("bb_bursts", rd_bursts - burst_base, 2);

    // Round-robin with both sides requesting continuously from reset
    rst = 1'b1;
    i_rd = 1'b1; i_addr = 64'h4000;
    d_rd = 1'b1; d_addr = 64'h5000;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      addr_k  = (k % 2 == 0) ? 64'h4000 : 64'h5000;
      rdata_k = {16{32'h0 + k}};
      tick;
      check("rr_h_rd", h_rd, 1);
      check("rr_h_addr", h_addr, addr_k);
      h_dv = 1'b1; h_rdata = rdata_k;
      tick;
      h_dv = 1'b0;
      if (k % 2 == 0) begin
        check("rr_i_dv", i_dv, 1);
        check("rr_i_data", i_data, rdata_k);
        check("rr_d_idle", d_dv, 0);
      end else begin
        check("rr_d_dv", d_dv, 1);
        check("rr_d_rdata", d_rdata, rdata_k);
        check("rr_i_idle", i_dv, 0);
      end
      tick;
      check("rr_done_gap", h_rd, 0);
    end
    i_rd = 1'b0; d_rd = 1'b0;
    tick; tick;

    // Reset during a write
    d_wr = 1'b1; d_addr = 64'h6000; d_wdata = LineW1;
    tick;
    check("mr_h_wr", h_wr, 1);
    rst = 1'b1;
    #1;
    check("mr_h_wr_async", h_wr, 0);
    check("mr_h_addr_async", h_addr, 0);
    check("mr_inv", inv, 0);
    check("mr_d_dv", d_dv, 0);
    d_wr = 1'b0;
    tick;
    rst = 1'b0;
    h_dv = 1'b1; h_rdata = LineJunk;
    tick;
    h_dv = 1'b0;
    check("mr_late_d_dv", d_dv, 0);
    check("mr_late_inv", inv, 0);
    tick; tick;
    check("mr_idle_h_rd", h_rd, 0);
    check("mr_idle_h_wr", h_wr, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
